// File: rtl/frame_buf_pkg.sv
// Shared constants for the LPC frame buffer: frame width, slot geometry and
// drop counter width.
package frame_buf_pkg;
  localparam int FRAME_W    = 48;
  localparam int SLOT_BYTES = 8;
  localparam int SLOT_SHIFT = 3;
  localparam int DROP_CNT_W = 16;
endpackage

// File: rtl/ring_ptr.sv
// Ring pointer: PW-bit counter (slot index plus wrap bit) with increment and
// load. Load has priority over increment.
module ring_ptr #(
  parameter int PW = 6
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_inc,
  input  logic          i_load,
  input  logic [PW-1:0] i_load_val,
  output logic [PW-1:0] o_ptr
);
  logic [PW-1:0] r_ptr;

  // pointer register: reset to 0, load wins over increment
  always_ff @(posedge clock) begin
    if (reset)       r_ptr <= '0;
    else if (i_load) r_ptr <= i_load_val;
    else if (i_inc)  r_ptr <= r_ptr + 1'b1;
  end

  assign o_ptr = r_ptr;
endmodule

// File: rtl/frame_ring_ctrl.sv
// Slot-level ring-buffer controller between the LPC frame decoder and the
// UART frame drainer. Owns write/read slot pointers, retires a slot on the
// drainer's read_done rising edge, supports flush and drops frames when full.
// Optional macro FRAME_DROP_CNT_EN enables the saturating drop counter;
// without it drop_count is tied to zero.
module frame_ring_ctrl
  import frame_buf_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    capture_en,
  input  logic                    flush,
  input  logic                    frame_valid,
  input  logic [FRAME_W-1:0]      frame_data,
  output logic                    ram_wr_en,
  output logic [AW-SLOT_SHIFT-1:0] ram_wr_slot,
  output logic [FRAME_W-1:0]      ram_wr_data,
  output logic [AW-SLOT_SHIFT-1:0] target_addr,
  output logic                    read_empty,
  input  logic                    read_done,
  output logic [AW-SLOT_SHIFT:0]  fill_level,
  output logic                    overflow,
  output logic [DROP_CNT_W-1:0]   drop_count
);
  localparam int SW = AW - SLOT_SHIFT;
  localparam logic [SW:0] FULL_XOR = {1'b1, {SW{1'b0}}};

  logic [SW:0]          w_wr_ptr, w_rd_ptr, w_wr_next, w_rd_new, w_flush_ptr;
  logic                 w_empty, w_full, w_done_rise, w_retire;
  logic                 w_frame_in, w_accept, w_drop, w_in_flight;
  logic                 r_done_q, r_wr_en, r_overflow;
  logic [SW-1:0]        r_wr_slot;
  logic [FRAME_W-1:0]   r_wr_data;

  assign w_empty     = (w_wr_ptr == w_rd_ptr);
  assign w_done_rise = read_done & ~r_done_q;
  assign w_retire    = w_done_rise & ~w_empty;

  // A write registered last cycle commits to wr_ptr at the end of this one, so
  // the full test and the next slot index must already include it.
  assign w_wr_next   = w_wr_ptr + {{SW{1'b0}}, r_wr_en};
  assign w_full      = ((w_wr_next ^ w_rd_ptr) == FULL_XOR);

  // flush wins over an arriving frame: neither written nor counted as a drop
  assign w_frame_in  = frame_valid & capture_en & ~flush;
  assign w_accept    = w_frame_in & ~w_full;
  assign w_drop      = w_frame_in & w_full;

  // Flush keeps the slot the drainer is working on; a retire in the same
  // cycle is applied first (read_done=1 then means nothing is in flight).
  assign w_in_flight = ~w_empty & ~read_done;
  assign w_rd_new    = w_rd_ptr + {{SW{1'b0}}, w_retire};
  assign w_flush_ptr = w_rd_new + {{SW{1'b0}}, w_in_flight};

  ring_ptr #(.PW(SW+1)) u_wr_ptr (
    .clock      (clock),
    .reset      (reset),
    .i_inc      (r_wr_en),
    .i_load     (flush),
    .i_load_val (w_flush_ptr),
    .o_ptr      (w_wr_ptr)
  );

  ring_ptr #(.PW(SW+1)) u_rd_ptr (
    .clock      (clock),
    .reset      (reset),
    .i_inc      (w_retire),
    .i_load     (1'b0),
    .i_load_val ({(SW+1){1'b0}}),
    .o_ptr      (w_rd_ptr)
  );

  // RAM write stage: register strobe, slot and frame one cycle after arrival
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_slot <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wr_slot <= w_wr_next[SW-1:0];
        r_wr_data <= frame_data;
      end
    end
  end

  // read_done history for rising-edge detection; starts high so a drainer
  // already idle-high after reset does not fake a retire
  always_ff @(posedge clock) begin
    if (reset) r_done_q <= 1'b1;
    else       r_done_q <= read_done;
  end

  // sticky overflow: set on a drop, cleared by flush
  always_ff @(posedge clock) begin
    if (reset)       r_overflow <= 1'b0;
    else if (flush)  r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

`ifdef FRAME_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  // saturating drop counter, untouched by flush
  always_ff @(posedge clock) begin
    if (reset) r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != {DROP_CNT_W{1'b1}}))
      r_drop_cnt <= r_drop_cnt + 1'b1;
  end

  assign drop_count = r_drop_cnt;
`else
  assign drop_count = '0;
`endif

  assign ram_wr_en   = r_wr_en;
  assign ram_wr_slot = r_wr_slot;
  assign ram_wr_data = r_wr_data;
  assign target_addr = w_rd_ptr[SW-1:0];
  assign read_empty  = w_empty | w_done_rise;
  assign fill_level  = w_wr_ptr - w_rd_ptr;
  assign overflow    = r_overflow;
endmodule

// File: tb/tb_frame_ring_ctrl.sv
// Self-checking bench for frame_ring_ctrl (AW=8, 32 slots). Reference model
// tracks total frames written/retired as unbounded integers; slot indices and
// occupancy follow from plain modular arithmetic.
module tb_frame_ring_ctrl;
  localparam int AW = 8;
  localparam int D  = 32;

  logic        clock = 1'b0;
  logic        reset, capture_en, flush, frame_valid, read_done;
  logic [47:0] frame_data;
  logic        ram_wr_en, read_empty, overflow;
  logic [4:0]  ram_wr_slot, target_addr;
  logic [47:0] ram_wr_data;
  logic [5:0]  fill_level;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_wr, m_rd, m_drops, m_pslot;
  bit          m_pend, m_ovf, m_doneq;
  logic [47:0] m_pdata;

  frame_ring_ctrl #(.AW(AW)) dut (
    .clock(clock), .reset(reset), .capture_en(capture_en), .flush(flush),
    .frame_valid(frame_valid), .frame_data(frame_data),
    .ram_wr_en(ram_wr_en), .ram_wr_slot(ram_wr_slot), .ram_wr_data(ram_wr_data),
    .target_addr(target_addr), .read_empty(read_empty), .read_done(read_done),
    .fill_level(fill_level), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  function automatic logic [5:0] exp_fill();
    return 6'(m_wr - m_rd);
  endfunction

  function automatic logic [4:0] exp_target();
    return 5'(m_rd % D);
  endfunction

  function automatic logic exp_empty();
    return (m_wr == m_rd) || (read_done && !m_doneq);
  endfunction

  function automatic logic [15:0] exp_drops();
`ifdef FRAME_DROP_CNT_EN
    return 16'(m_drops);
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic [47:0] rnd48();
    return {16'($urandom), $urandom};
  endfunction

  // advance model with the inputs present before the edge, then clock once
  task automatic tick();
    bit rise, retire, fin, inflight;
    int occ, rd_new;
    if (reset) begin
      m_wr = 0; m_rd = 0; m_pend = 0; m_pslot = 0; m_pdata = '0;
      m_ovf = 0; m_drops = 0; m_doneq = 1;
    end else begin
      rise     = read_done && !m_doneq;
      retire   = rise && (m_wr != m_rd);
      inflight = (m_wr != m_rd) && !read_done;
      occ      = m_wr + int'(m_pend) - m_rd;
      fin      = frame_valid && capture_en && !flush;
      rd_new   = m_rd + int'(retire);
      if (fin && occ >= D && m_drops < 65535) m_drops++;
      if (flush)                m_ovf = 0;
      else if (fin && occ >= D) m_ovf = 1;
      if (fin && occ < D) begin
        m_pslot = (m_wr + int'(m_pend)) % D;
        m_pdata = frame_data;
      end
      if (flush) m_wr = rd_new + int'(inflight);
      else       m_wr = m_wr + int'(m_pend);
      m_rd    = rd_new;
      m_pend  = fin && occ < D;
      m_doneq = read_done;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1; capture_en = 0; flush = 0; frame_valid = 0; read_done = 0;
    frame_data = '0;
    tick(); tick();
    reset = 0;
    capture_en = 1;
  endtask

  task automatic push_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_valid = 1; frame_data = rnd48(); tick();
    end
    frame_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    capture_en = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      checks++;
      if (read_empty !== 1'b1 || fill_level !== 6'd0 || target_addr !== 5'd0 || ram_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: empty=%b fill=%0d target=%0d wr_en=%b, want 1/0/0/0",
                 i, read_empty, fill_level, target_addr, ram_wr_en);
      end
      tick();
    end
    #1;
    checks++;
    if (overflow !== 1'b0 || drop_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_flags: overflow=%b drop=%0d want 0/0", overflow, drop_count);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    frame_valid = 1; frame_data = 48'h0102_0304_0506;
    tick();
    frame_valid = 0;
    #1;
    checks++;
    if (ram_wr_en !== 1'b1 || ram_wr_slot !== 5'd0 || ram_wr_data !== 48'h0102_0304_0506) begin
      errors++;
      $display("FAIL single_write: en=%b slot=%0d data=%h want 1/0/010203040506",
               ram_wr_en, ram_wr_slot, ram_wr_data);
    end
    checks++;
    if (read_empty !== 1'b1) begin
      errors++;
      $display("FAIL single_early_empty: empty=%b want 1", read_empty);
    end
    tick(); #1;
    checks++;
    if (read_empty !== 1'b0 || fill_level !== 6'd1) begin
      errors++;
      $display("FAIL single_visible: empty=%b fill=%0d want 0/1", read_empty, fill_level);
    end
  endtask

  task automatic test_back_to_back();
    int writes = 0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      frame_valid = 1; frame_data = rnd48();
      tick(); #1;
      checks++;
      if (ram_wr_en !== m_pend || (m_pend && (ram_wr_slot !== 5'(m_pslot) || ram_wr_data !== m_pdata))) begin
        errors++;
        $display("FAIL b2b_write %0d: en=%b slot=%0d want en=%b slot=%0d", i, ram_wr_en, ram_wr_slot, m_pend, m_pslot);
      end
      if (ram_wr_en === 1'b1) begin
        checks++;
        if (ram_wr_slot !== 5'(writes)) begin
          errors++;
          $display("FAIL b2b_slot_order: slot=%0d want %0d", ram_wr_slot, writes);
        end
        writes++;
      end
    end
    frame_valid = 0;
    tick(); tick(); #1;
    checks++;
    if (writes != 32 || fill_level !== 6'd32 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL b2b_full: writes=%0d fill=%0d ovf=%b want 32/32/1", writes, fill_level, overflow);
    end
    checks++;
`ifdef FRAME_DROP_CNT_EN
    if (drop_count !== 16'd8) begin
`else
    if (drop_count !== 16'd0) begin
`endif
      errors++;
      $display("FAIL b2b_drops: drop=%0d want %0d", drop_count, exp_drops());
    end
  endtask

  task automatic test_retire_wrap();
    do_reset();
    push_frames(3);
    tick(); tick();
    for (int i = 0; i < 34; i++) begin
      push_frames(1);
      tick(); tick();
      read_done = 0; tick();
      read_done = 1; #1;
      checks++;
      if (read_empty !== 1'b1 || exp_empty() !== 1'b1 || target_addr !== 5'(i % D)) begin
        errors++;
        $display("FAIL retire_rise %0d: empty=%b target=%0d want 1/%0d", i, read_empty, target_addr, i % D);
      end
      tick(); #1;
      checks++;
      if (target_addr !== 5'((i + 1) % D) || target_addr !== exp_target() || read_empty !== 1'b0) begin
        errors++;
        $display("FAIL retire_next %0d: target=%0d empty=%b want %0d/0", i, target_addr, read_empty, (i + 1) % D);
      end
    end
  endtask

  task automatic test_full_retire();
    do_reset();
    push_frames(32);
    tick(); tick();
    read_done = 0; tick();
    read_done = 1; frame_valid = 1; frame_data = rnd48();
    tick();
    frame_valid = 0; #1;
    checks++;
    if (ram_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL full_retire_wr: en=%b want 0", ram_wr_en);
    end
    tick(); tick(); #1;
    checks++;
    if (fill_level !== 6'd31 || fill_level !== exp_fill() || overflow !== 1'b1) begin
      errors++;
      $display("FAIL full_retire_fill: fill=%0d ovf=%b want 31/1", fill_level, overflow);
    end
  endtask

  task automatic test_flush();
    logic [15:0] saved;
    do_reset();
    push_frames(5);
    tick(); tick();
    flush = 1; tick(); flush = 0; #1;
    checks++;
    if (fill_level !== 6'd1 || target_addr !== 5'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL flush_keep: fill=%0d target=%0d ovf=%b want 1/0/0", fill_level, target_addr, overflow);
    end
    push_frames(33);
    tick(); tick(); #1;
    saved = drop_count;
    checks++;
    if (fill_level !== 6'd32 || overflow !== 1'b1 || drop_count !== exp_drops()) begin
      errors++;
      $display("FAIL flush_refill: fill=%0d ovf=%b drop=%0d want 32/1/%0d", fill_level, overflow, drop_count, exp_drops());
    end
    flush = 1; frame_valid = 1; frame_data = rnd48();
    tick();
    flush = 0; frame_valid = 0; #1;
    checks++;
    if (ram_wr_en !== 1'b0 || drop_count !== saved || overflow !== 1'b0 || fill_level !== 6'd1) begin
      errors++;
      $display("FAIL flush_with_frame: en=%b drop=%0d ovf=%b fill=%0d want 0/%0d/0/1",
               ram_wr_en, drop_count, overflow, fill_level, saved);
    end
    // not in flight: read_done high, flush empties the ring completely
    read_done = 1; tick(); tick();
    push_frames(3); tick(); tick();
    flush = 1; tick(); flush = 0; #1;
    checks++;
    if (fill_level !== exp_fill() || read_empty !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle: fill=%0d empty=%b want %0d/1", fill_level, read_empty, exp_fill());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(0, 599) == 0);
      capture_en  = ($urandom_range(0, 9) != 0);
      flush       = ($urandom_range(0, 39) == 0);
      frame_valid = ($urandom_range(0, 1) == 1);
      frame_data  = rnd48();
      if ($urandom_range(0, 9) < 3) read_done = ~read_done;
      #1;
      checks++;
      if (fill_level !== exp_fill() || target_addr !== exp_target() || read_empty !== exp_empty()) begin
        errors++;
        $display("FAIL rand_ptrs cyc %0d: fill=%0d target=%0d empty=%b want %0d/%0d/%b",
                 i, fill_level, target_addr, read_empty, exp_fill(), exp_target(), exp_empty());
      end
      checks++;
      if (ram_wr_en !== m_pend || (m_pend && (ram_wr_slot !== 5'(m_pslot) || ram_wr_data !== m_pdata))) begin
        errors++;
        $display("FAIL rand_write cyc %0d: en=%b slot=%0d data=%h want %b/%0d/%h",
                 i, ram_wr_en, ram_wr_slot, ram_wr_data, m_pend, m_pslot, m_pdata);
      end
      checks++;
      if (overflow !== m_ovf || drop_count !== exp_drops()) begin
        errors++;
        $display("FAIL rand_flags cyc %0d: ovf=%b drop=%0d want %b/%0d", i, overflow, drop_count, m_ovf, exp_drops());
      end
      tick();
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_retire_wrap();
    test_full_retire();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
